// File: rtl/hazard_unit_param_if.sv
// hazard_unit_param_if
//   Bundles the decoder-to-hazard-unit signals of the D stage and the
//   stall/forward-select results returned to the datapath.
//
//   Decoder side (master drives, slave reads):
//     d_rs, d_rt        source register fields of the instruction in D
//     d_tuse_rs/rt      cycles until the operand is consumed (3 = unused)
//     d_dst, d_tnew     destination register (0 = none) and result latency
//     d_md_start        instruction is mult/div; d_md_div selects div
//     d_hilo_use        instruction reads or writes HI/LO
//   Hazard side (slave drives, master reads):
//     stall             hold PC and D, bubble into E
//     fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
//                       forward selects (0 = regfile/pipeline, s = stage s)
//     md_busy           mult/div unit occupied
//     stall_cnt, md_stall_cnt
//                       performance counters, present only when
//                       HAZ_PERF_CNT_EN is defined
interface hazard_unit_param_if #(
  parameter int SELW = 2
);
  logic [4:0]      d_rs;
  logic [4:0]      d_rt;
  logic [1:0]      d_tuse_rs;
  logic [1:0]      d_tuse_rt;
  logic [4:0]      d_dst;
  logic [1:0]      d_tnew;
  logic            d_md_start;
  logic            d_md_div;
  logic            d_hilo_use;

  logic            stall;
  logic [SELW-1:0] fwd_rs_d;
  logic [SELW-1:0] fwd_rt_d;
  logic [SELW-1:0] fwd_rs_e;
  logic [SELW-1:0] fwd_rt_e;
  logic [SELW-1:0] fwd_rt_m;
  logic            md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     md_stall_cnt;
`endif

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_hilo_use,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
           md_busy
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, md_stall_cnt
`endif
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_hilo_use,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
           md_busy
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, md_stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_unit_param.sv
// hazard_unit_param
//   Parameterised hazard unit for an in-order pipeline. Tracks in-flight
//   register writes as (valid, dst, tnew) tags in a shift pipeline with one
//   entry per stage after D, produces forward selects for the D, E and M
//   operands, and raises the D-stage stall from a Tuse/Tnew comparison.
//   A mult/div busy counter additionally stalls HI/LO accesses.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears every tag, operand copy and
//            the mult/div counter, so all outputs read 0 at once
//     hz     hazard_unit_param_if.slave: D-stage decode inputs in,
//            stall / forward selects / md_busy out
//
//   Parameters:
//     DEPTH     tracked stages after D (1=E, 2=M, 3=W, ...), at least 3
//     MULT_LAT  busy cycles after a mult enters E
//     DIV_LAT   busy cycles after a div enters E
//     SELW      forward select width, must be able to hold DEPTH
//
//   Build option: define HAZ_PERF_CNT_EN to add hz.stall_cnt (stalled
//   cycles) and hz.md_stall_cnt (cycles stalled only by the HI/LO rule).
module hazard_unit_param #(
  parameter int DEPTH    = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SELW     = 2
) (
  input  logic               clk,
  input  logic               reset,
  hazard_unit_param_if.slave hz
);

  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_W   = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

  typedef struct packed {
    logic            hit;
    logic [1:0]      tnew;
    logic [SELW-1:0] sel;
  } match_t;

  // Remaining latency of a tag that advances one stage.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Youngest tag at stage >= first that writes r. The select only names
  // that stage once its result exists; an older match is never used
  // past a younger one because the younger one overwrites it below.
  function automatic match_t find_youngest(
    input logic [4:0]          r,
    input int                  first,
    input logic [DEPTH:1]      vld,
    input logic [DEPTH:1][4:0] dst,
    input logic [DEPTH:1][1:0] tnew
  );
    match_t m;
    m = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (s >= first && vld[s] && dst[s] == r && r != 5'd0) begin
        m.hit  = 1'b1;
        m.tnew = tnew[s];
        m.sel  = (tnew[s] == 2'd0) ? SELW'(s) : '0;
      end
    end
    return m;
  endfunction

  // The producer is still too far from its result when the consumer
  // needs the value; tuse 3 marks an operand that is never read.
  function automatic logic must_wait(input match_t m, input logic [1:0] tuse);
    return m.hit && (tuse != 2'd3) && (m.tnew > tuse);
  endfunction

  logic [DEPTH:1]      vld_p;
  logic [DEPTH:1][4:0] dst_p;
  logic [DEPTH:1][1:0] tnew_p;

  logic [4:0]          rs_p1;
  logic [4:0]          rt_p1;
  logic [4:0]          rt_p2;
  logic                md_p1;
  logic [MD_W-1:0]     md_cnt;

  match_t              m_rs_d;
  match_t              m_rt_d;
  match_t              m_rs_e;
  match_t              m_rt_e;
  match_t              m_rt_m;
  logic                data_stall;
  logic                hilo_stall;
  logic                stall_w;
  logic                md_busy_w;

  // D stage: hazard detection and forward selects, all combinational
  always_comb begin
    m_rs_d     = find_youngest(hz.d_rs, 1, vld_p, dst_p, tnew_p);
    m_rt_d     = find_youngest(hz.d_rt, 1, vld_p, dst_p, tnew_p);
    m_rs_e     = find_youngest(rs_p1,   2, vld_p, dst_p, tnew_p);
    m_rt_e     = find_youngest(rt_p1,   2, vld_p, dst_p, tnew_p);
    m_rt_m     = find_youngest(rt_p2,   3, vld_p, dst_p, tnew_p);

    md_busy_w  = (md_cnt != '0);
    data_stall = must_wait(m_rs_d, hz.d_tuse_rs) ||
                 must_wait(m_rt_d, hz.d_tuse_rt);
    // md_p1 is covered by md_busy once the counter has loaded; it is kept
    // so the rule still holds for a latency of zero.
    hilo_stall = hz.d_hilo_use && (md_busy_w || md_p1);
    stall_w    = data_stall || hilo_stall;
  end

  assign hz.stall    = stall_w;
  assign hz.md_busy  = md_busy_w;
  assign hz.fwd_rs_d = m_rs_d.sel;
  assign hz.fwd_rt_d = m_rt_d.sel;
  assign hz.fwd_rs_e = m_rs_e.sel;
  assign hz.fwd_rt_e = m_rt_e.sel;
  assign hz.fwd_rt_m = m_rt_m.sel;

  // D -> E boundary (stage 1) and onward shift through stages 2..DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p  <= '0;
      dst_p  <= '0;
      tnew_p <= '0;
      rs_p1  <= '0;
      rt_p1  <= '0;
      rt_p2  <= '0;
      md_p1  <= 1'b0;
    end else begin
      for (int s = DEPTH; s >= 2; s--) begin
        vld_p[s]  <= vld_p[s-1];
        dst_p[s]  <= dst_p[s-1];
        tnew_p[s] <= sat_dec(tnew_p[s-1]);
      end
      if (stall_w) begin
        vld_p[1]  <= 1'b0;
        dst_p[1]  <= 5'd0;
        tnew_p[1] <= 2'd0;
        rs_p1     <= 5'd0;
        rt_p1     <= 5'd0;
        md_p1     <= 1'b0;
      end else begin
        vld_p[1]  <= (hz.d_dst != 5'd0);
        dst_p[1]  <= hz.d_dst;
        tnew_p[1] <= hz.d_tnew;
        rs_p1     <= hz.d_rs;
        rt_p1     <= hz.d_rt;
        md_p1     <= hz.d_md_start;
      end
      rt_p2 <= rt_p1;
    end
  end

  // E stage: mult/div occupancy, loaded as the instruction enters E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (!stall_w && hz.d_md_start) begin
      md_cnt <= hz.d_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;

  // Stall accounting, sampled at the same edge that holds D
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall_w) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (hilo_stall && !data_stall) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end

  assign hz.stall_cnt    = stall_cnt;
  assign hz.md_stall_cnt = md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
// Testbench for hazard_unit_param. The reference model keeps a per-cycle
// history of what entered E; stage s in cycle c holds the entry of cycle
// c-s, and its remaining latency is its tnew minus the stages travelled.
module tb_hazard_unit_param;
  localparam int DEPTH    = 3;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int SELW     = 2;
  localparam int MAXC     = 8192;

  logic clk;
  logic reset;

  hazard_unit_param_if #(.SELW(SELW)) hz ();

  hazard_unit_param #(
    .DEPTH(DEPTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .SELW(SELW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model history
  bit         e_vld [MAXC];
  logic [4:0] e_dst [MAXC];
  int         e_tnew[MAXC];
  logic [4:0] e_rs  [MAXC];
  logic [4:0] e_rt  [MAXC];
  int cyc     = 0;
  int rst_cyc = 0;
  int md_cyc  = -100;
  int md_lat  = 0;
  int pc_stall = 0;
  int pc_md    = 0;
  bit m_stall, m_data_stall;
  int obs_stall, obs_fwd_rs_d, obs_fwd_rt_d, obs_fwd_rs_e, obs_fwd_rt_m;

  task automatic mfind(input logic [4:0] r, input int first,
                       output bit hit, output int tn, output int sel);
    hit = 0; tn = 0; sel = 0;
    if (r == 5'd0) return;
    for (int s = first; s <= DEPTH; s++) begin
      int idx;
      idx = cyc - s;
      if (idx >= rst_cyc && e_vld[idx] && e_dst[idx] == r) begin
        hit = 1;
        tn  = e_tnew[idx] - (s - 1);
        if (tn < 0) tn = 0;
        sel = (tn == 0) ? s : 0;
        return;
      end
    end
  endtask

  task automatic advance();
    if (!m_stall) begin
      e_vld[cyc]  = (hz.d_dst != 5'd0);
      e_dst[cyc]  = hz.d_dst;
      e_tnew[cyc] = int'(hz.d_tnew);
      e_rs[cyc]   = hz.d_rs;
      e_rt[cyc]   = hz.d_rt;
      if (hz.d_md_start) begin
        md_cyc = cyc;
        md_lat = hz.d_md_div ? DIV_LAT : MULT_LAT;
      end
    end else begin
      e_vld[cyc] = 0;
      e_rs[cyc]  = 5'd0;
      e_rt[cyc]  = 5'd0;
    end
    if (m_stall) pc_stall++;
    if (m_stall && !m_data_stall) pc_md++;
    cyc++;
  endtask

  // One clock: evaluate the model, compare at the falling edge, advance.
  task automatic step();
    bit h;
    int tn, x_rs_d, x_rt_d, x_rs_e, x_rt_e, x_rt_m;
    logic [4:0] er, et, mr;
    bit busy;
    @(negedge clk);
    m_data_stall = 0;
    mfind(hz.d_rs, 1, h, tn, x_rs_d);
    if (h && hz.d_tuse_rs != 2'd3 && tn > int'(hz.d_tuse_rs)) m_data_stall = 1;
    mfind(hz.d_rt, 1, h, tn, x_rt_d);
    if (h && hz.d_tuse_rt != 2'd3 && tn > int'(hz.d_tuse_rt)) m_data_stall = 1;
    er = 5'd0; et = 5'd0; mr = 5'd0;
    if (cyc - 1 >= rst_cyc) begin er = e_rs[cyc-1]; et = e_rt[cyc-1]; end
    if (cyc - 2 >= rst_cyc) mr = e_rt[cyc-2];
    mfind(er, 2, h, tn, x_rs_e);
    mfind(et, 2, h, tn, x_rt_e);
    mfind(mr, 3, h, tn, x_rt_m);
    busy    = (md_cyc >= rst_cyc) && (cyc - md_cyc <= md_lat);
    m_stall = m_data_stall || (hz.d_hilo_use && busy);

    obs_stall    = int'(hz.stall);
    obs_fwd_rs_d = int'(hz.fwd_rs_d);
    obs_fwd_rt_d = int'(hz.fwd_rt_d);
    obs_fwd_rs_e = int'(hz.fwd_rs_e);
    obs_fwd_rt_m = int'(hz.fwd_rt_m);
    chk("stall",    obs_stall,          int'(m_stall));
    chk("md_busy",  int'(hz.md_busy),   int'(busy));
    chk("fwd_rs_d", obs_fwd_rs_d,       x_rs_d);
    chk("fwd_rt_d", obs_fwd_rt_d,       x_rt_d);
    chk("fwd_rs_e", obs_fwd_rs_e,       x_rs_e);
    chk("fwd_rt_e", int'(hz.fwd_rt_e),  x_rt_e);
    chk("fwd_rt_m", obs_fwd_rt_m,       x_rt_m);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt",    int'(hz.stall_cnt),    pc_stall);
    chk("md_stall_cnt", int'(hz.md_stall_cnt), pc_md);
`endif
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, rt, dst,
                       input logic [1:0] tur, tut, tnew,
                       input bit md, dv, hl);
    hz.d_rs = rs; hz.d_rt = rt; hz.d_dst = dst;
    hz.d_tuse_rs = tur; hz.d_tuse_rt = tut; hz.d_tnew = tnew;
    hz.d_md_start = md; hz.d_md_div = dv; hz.d_hilo_use = hl;
  endtask

  // Present an instruction in D and hold it while the pipeline stalls.
  task automatic issue(input logic [4:0] rs, rt, dst,
                       input logic [1:0] tur, tut, tnew,
                       input bit md, dv, hl, output int nstall);
    drive(rs, rt, dst, tur, tut, tnew, md, dv, hl);
    nstall = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!m_stall) break;
      nstall++;
    end
    chk("stall_bound", int'(m_stall), 0);
  endtask

  task automatic nops(input int n);
    int ns;
    for (int k = 0; k < n; k++) issue(0, 0, 0, 3, 3, 0, 0, 0, 0, ns);
  endtask

  // Reset pulse between clock edges; outputs must drop without a clock.
  task automatic mid_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_stall",    int'(hz.stall),    0);
    chk("rst_md_busy",  int'(hz.md_busy),  0);
    chk("rst_fwd_rs_d", int'(hz.fwd_rs_d), 0);
    chk("rst_fwd_rt_d", int'(hz.fwd_rt_d), 0);
    chk("rst_fwd_rs_e", int'(hz.fwd_rs_e), 0);
    chk("rst_fwd_rt_e", int'(hz.fwd_rt_e), 0);
    chk("rst_fwd_rt_m", int'(hz.fwd_rt_m), 0);
    #1 reset = 1'b0;
    rst_cyc  = cyc;
    pc_stall = 0;
    pc_md    = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    logic [4:0] r_rs, r_rt, r_dst;
    logic [1:0] r_tur, r_tut, r_tnew;
    bit r_md, r_dv, r_hl;

    reset = 1'b1;
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0);
    #7;
    chk("init_stall",    int'(hz.stall),    0);
    chk("init_md_busy",  int'(hz.md_busy),  0);
    chk("init_fwd_rs_d", int'(hz.fwd_rs_d), 0);
    chk("init_fwd_rt_m", int'(hz.fwd_rt_m), 0);
    #1 reset = 1'b0;

    // addu $3,$1,$2 ; addu $4,$3,$1
    issue(1, 2, 3, 1, 1, 1, 0, 0, 0, ns);
    issue(3, 1, 4, 1, 1, 1, 0, 0, 0, ns);
    chk("addu_nostall", ns, 0);
    nops(1);
    chk("addu_fwd_rs_e", obs_fwd_rs_e, 2);
    nops(4);

    // lw $5,0($0) ; beq $5,$0
    issue(0, 0, 5, 1, 3, 2, 0, 0, 0, ns);
    issue(5, 0, 0, 0, 0, 0, 0, 0, 0, ns);
    chk("lw_beq_stalls", ns, 2);
    chk("lw_beq_fwd_rs_d", obs_fwd_rs_d, 3);
    nops(4);

    // lw $6,0($0) ; sw $6,4($0)
    issue(0, 0, 6, 1, 3, 2, 0, 0, 0, ns);
    issue(0, 6, 0, 1, 2, 0, 0, 0, 0, ns);
    chk("lw_sw_nostall", ns, 0);
    nops(2);
    chk("lw_sw_fwd_rt_m", obs_fwd_rt_m, 3);
    nops(4);

    // ori $0,$0,1 ; beq $0,$0
    issue(0, 0, 0, 1, 3, 1, 0, 0, 0, ns);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, ns);
    chk("zero_nostall", ns, 0);
    chk("zero_fwd_rs_d", obs_fwd_rs_d, 0);
    chk("zero_fwd_rt_d", obs_fwd_rt_d, 0);
    nops(4);

    // div $1,$2 ; mflo $7
    issue(1, 2, 0, 1, 1, 0, 1, 1, 1, ns);
    issue(0, 0, 7, 3, 3, 1, 0, 0, 1, ns);
    chk("div_mflo_stalls", ns, DIV_LAT);
    nops(4);

    // div then mflo, reset while mflo is held
    issue(1, 2, 0, 1, 1, 0, 1, 1, 1, ns);
    drive(0, 0, 7, 3, 3, 1, 0, 0, 1);
    step();
    step();
    chk("pre_rst_stall", obs_stall, 1);
    mid_reset();
    issue(0, 0, 7, 3, 3, 1, 0, 0, 1, ns);
    chk("post_rst_nostall", ns, 0);
    nops(4);

    // mult ; mfhi
    issue(3, 4, 0, 1, 1, 0, 1, 0, 1, ns);
    issue(0, 0, 8, 3, 3, 1, 0, 0, 1, ns);
    chk("mult_mfhi_stalls", ns, MULT_LAT);

    // Random instruction stream
    for (int i = 0; i < 250; i++) begin
      r_rs   = 5'($urandom_range(0, 3));
      r_rt   = 5'($urandom_range(0, 3));
      r_dst  = 5'($urandom_range(0, 3));
      r_tur  = 2'($urandom_range(0, 3));
      r_tut  = 2'($urandom_range(0, 3));
      r_tnew = 2'($urandom_range(0, 2));
      r_md   = ($urandom_range(0, 15) == 0);
      r_dv   = ($urandom_range(0, 1) == 1);
      r_hl   = r_md || ($urandom_range(0, 7) == 0);
      issue(r_rs, r_rt, r_dst, r_tur, r_tut, r_tnew, r_md, r_dv, r_hl, ns);
      if (i == 120) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parameterised successor to the fixed five-stage forwarding selector.
- Tracks in-flight register writes in an internal shift pipeline of (dst, tnew, valid) tags, one entry per stage after D.
- Computes forwarding selects for D, E and M operands and generates the D-stage stall from Tuse/Tnew comparison.
- Adds a multi-cycle mult/div busy tracker that stalls HI/LO accesses. Sits beside the datapath and is fed by the decoder in D.

Parameters:
- DEPTH, 3, number of tracked stages after D (1=E, 2=M, 3=W, ...); minimum 3.
- MULT_LAT, 5, cycles the mult unit is busy after a mult enters E.
- DIV_LAT, 10, cycles the div unit is busy after a div enters E.
- SELW, 2, width of each forward select; must hold the value DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_rs  in  5  rs field of the instruction in D.
- d_rt  in  5  rt field of the instruction in D.
- d_tuse_rs  in  2  cycles until rs is consumed (0 branch/jr, 1 ALU, 2 store data); 3 means unused.
- d_tuse_rt  in  2  same encoding, for rt.
- d_dst  in  5  destination register written by the D instruction; 0 means none.
- d_tnew  in  2  stage advances after entering E before the result is forwardable (ALU 1, load 2, link 0).
- d_md_start  in  1  D instruction is mult/div.
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult.
- d_hilo_use  in  1  D instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  hold PC and the D register; insert a bubble into E.
- fwd_rs_d  out  SELW  forward source for rs in D.
- fwd_rt_d  out  SELW  forward source for rt in D.
- fwd_rs_e  out  SELW  forward source for rs in E.
- fwd_rt_e  out  SELW  forward source for rt in E.
- fwd_rt_m  out  SELW  forward source for store data in M.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Select encoding: 0 = register-file or pipeline value; s = stage s output register (1=E/M boundary value, 2=M, 3=W, ...).
- Internal state:
  - tag[s] = {valid, dst, tnew} for s=1..DEPTH.
  - E-stage copies of rs/rt, M-stage copy of rt.
  - md counter, wide enough for max(MULT_LAT, DIV_LAT).
- Every cycle, each tag moves s to s+1. The tnew of a moving tag decrements, saturating at 0. The tag leaving DEPTH is dropped.
- tag[1] load:
  - If stall=0, loads {d_dst!=0, d_dst, d_tnew}, and the E operand copies load d_rs/d_rt.
  - If stall=1, loads bubble {0,0,0}, and the E copies load 0.
- Match rule for operand register r at stage s: valid, dst==r, r!=0.
- Forward select:
  - The youngest matching stage wins.
  - If its tnew==0, the select is s; otherwise the select is 0.
  - Older matches are never used past a younger match.
- Search range by operand:
  - D operands search s>=1.
  - E operands search s>=2.
  - M rt searches s>=3.
- Data stall: youngest D match with tnew > tuse for rs or rt (tuse 3 never stalls).
- md counter:
  - When a D instruction with d_md_start enters E (stall=0), the counter loads DIV_LAT or MULT_LAT.
  - Otherwise it decrements to 0.
  - md_busy = (counter!=0).
- HI/LO stall: d_hilo_use && (md_busy || E tag holds an md start).
- stall = data stall OR HI/LO stall. Purely combinational from current state plus D inputs; no added latency.
- Forward selects are combinational and valid in the same cycle.
- Reset:
  - All tags invalid, tnew 0, operand copies 0, md counter 0.
  - stall, all selects and md_busy read 0 while reset is high and immediately after, regardless of the clock.
- Reset mid-stall or mid-div: state is cleared asynchronously. The first D instruction after release sees no hazards.
- The $0 destination never matches, never stalls and never forwards.
- Simultaneous md start and HI/LO use in D: HI/LO stall takes effect. The md instruction enters E only once md_busy clears.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Adds output stall_cnt [31:0], counting cycles with stall=1.
  - Adds output md_stall_cnt [31:0], counting cycles stalled only by the HI/LO rule.
  - Both counters wrap at 2^32 and are cleared by reset.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- addu $3,$1,$2 then addu $4,$3,$1 -> no stall; next cycle fwd_rs_e=2.
- lw $5,0($0) then beq $5,$0 -> stall=1 for 2 cycles, then fwd_rs_d=3, stall=0.
- lw $6,0($0) then sw $6,4($0) -> no stall; when sw is in M, fwd_rt_m=3.
- ori $0,$0,1 then beq $0,$0 -> stall=0, fwd_rs_d=fwd_rt_d=0.
- div $1,$2 then mflo $7 -> md_busy high 10 cycles (DIV_LAT=10); mflo stalled until md_busy=0.
- Assert reset during the div stall of the previous case -> stall, md_busy and all selects 0 immediately, before the next clk edge.
